// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver with a one-entry holding register,
// valid/ready handshake and sticky framing/overrun error flags.
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    input  logic             rx_ready,
    input  logic             clr_err,
    output logic [DBITS-1:0] data_out,
    output logic             rx_valid,
    output logic             rx_done,
    output logic             framing_error,
    output logic             overrun,
    output logic [1:0]       state_out
);

    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [NW-1:0] LAST_BIT  = NW'(DBITS - 1);
    localparam logic [4:0]    LAST_STOP = 5'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t           state, state_next;
    logic [4:0]       s_cnt, s_cnt_next;
    logic [NW-1:0]    n, n_next;
    logic [DBITS-1:0] shift, shift_next;
    logic [DBITS:0]   shift_ext;
    logic             rx_meta, rx_s;
    logic             frame_end, frame_good, frame_bad;

    // Two-flop synchronizer; the line idles high so reset to 1.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n     <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            s_cnt <= s_cnt_next;
            n     <= n_next;
            shift <= shift_next;
        end
    end

    assign shift_ext = {rx_s, shift};

    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        n_next     = n;
        shift_next = shift;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end
            START: begin
                // Mid start bit: a high line here means the fall was a glitch.
                if (sample_tick) begin
                    if (s_cnt == 5'd7) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_cnt_next = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (s_cnt == 5'd15) begin
                        shift_next = shift_ext[DBITS:1];
                        s_cnt_next = '0;
                        if (n == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (s_cnt == LAST_STOP) begin
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end else begin
                        s_cnt_next = s_cnt + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign frame_good = frame_end & rx_s;
    assign frame_bad  = frame_end & ~rx_s;

    // Holding register and flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            data_out      <= '0;
            rx_valid      <= 1'b0;
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_done <= frame_end;
            if (frame_good) begin
                data_out <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (frame_bad) begin
                framing_error <= 1'b1;
            end else if (clr_err) begin
                framing_error <= 1'b0;
            end
            if (frame_good && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are bit-banged at 16 ticks per bit
// with one sample_tick every 4 clocks.
module tb_uart_receiver;

    logic       clk_100MHz;
    logic       reset;
    logic       rx;
    logic       sample_tick;
    logic       rx_ready;
    logic       clr_err;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_done;
    logic       framing_error;
    logic       overrun;
    logic [1:0] state_out;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int done_cnt  = 0;
    int tick_idx  = 0;
    int ready_tick = 0;
    bit saw_start = 0;

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .rx           (rx),
        .sample_tick  (sample_tick),
        .rx_ready     (rx_ready),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .rx_done      (rx_done),
        .framing_error(framing_error),
        .overrun      (overrun),
        .state_out    (state_out)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    always @(negedge clk_100MHz) begin
        if (rx_done) done_cnt++;
        if (state_out == 2'b01) saw_start = 1'b1;
    end

    // One tick period; rx_ready pulses on the cycle carrying tick number ready_tick.
    task automatic tick_once();
        @(negedge clk_100MHz);
        tick_idx++;
        sample_tick = 1'b1;
        rx_ready = (tick_idx == ready_tick);
        @(negedge clk_100MHz);
        sample_tick = 1'b0;
        rx_ready = 1'b0;
        repeat (2) @(negedge clk_100MHz);
    endtask

    // Full frame plus a 16-tick idle gap; a bad stop bit goes high after 10 ticks.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        logic level;
        tick_idx = 0;
        for (int b = 0; b < 10; b++) begin
            level = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            for (int t = 0; t < 16; t++) begin
                if (b == 9 && !stop_ok) rx = (t < 10) ? 1'b0 : 1'b1;
                else if (t == 0) rx = level;
                tick_once();
            end
        end
        rx = 1'b1;
        for (int t = 0; t < 16; t++) tick_once();
    endtask

    task automatic test_reset();
        rx = 1'b1; sample_tick = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        @(negedge clk_100MHz);
        check_cnt++; if (state_out !== 2'b00) $display("[TB] FAIL reset_state: got %b expected 00", state_out); else pass_cnt++;
        check_cnt++; if (data_out !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", data_out); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); else pass_cnt++;
        check_cnt++; if (rx_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", rx_done); else pass_cnt++;
        check_cnt++; if (framing_error !== 1'b0) $display("[TB] FAIL reset_fe: got %b expected 0", framing_error); else pass_cnt++;
        check_cnt++; if (overrun !== 1'b0) $display("[TB] FAIL reset_ovr: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        int d0;
        d0 = done_cnt;
        send_frame(8'd65, 1'b1);
        check_cnt++; if (done_cnt - d0 !== 1) $display("[TB] FAIL single_done_pulses: got %0d expected 1", done_cnt - d0); else pass_cnt++;
        check_cnt++; if (data_out !== 8'h41) $display("[TB] FAIL single_data: got %h expected 41", data_out); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b expected 1", rx_valid); else pass_cnt++;
        check_cnt++; if (framing_error !== 1'b0) $display("[TB] FAIL single_fe: got %b expected 0", framing_error); else pass_cnt++;
        check_cnt++; if (state_out !== 2'b00) $display("[TB] FAIL single_state: got %b expected 00", state_out); else pass_cnt++;
    endtask

    task automatic test_consume();
        @(negedge clk_100MHz); rx_ready = 1'b1;
        @(negedge clk_100MHz); rx_ready = 1'b0;
        check_cnt++; if (rx_valid !== 1'b0) $display("[TB] FAIL consume_valid: got %b expected 0", rx_valid); else pass_cnt++;
        check_cnt++; if (data_out !== 8'h41) $display("[TB] FAIL consume_data_held: got %h expected 41", data_out); else pass_cnt++;
    endtask

    task automatic test_overrun();
        send_frame(8'h41, 1'b1);
        check_cnt++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_first_clean: got %b expected 0", overrun); else pass_cnt++;
        send_frame(8'hA5, 1'b1);
        check_cnt++; if (data_out !== 8'hA5) $display("[TB] FAIL ovr_data: got %h expected a5", data_out); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b1) $display("[TB] FAIL ovr_valid: got %b expected 1", rx_valid); else pass_cnt++;
        check_cnt++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); else pass_cnt++;
        @(negedge clk_100MHz); clr_err = 1'b1;
        @(negedge clk_100MHz); clr_err = 1'b0;
        check_cnt++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_cleared: got %b expected 0", overrun); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b1) $display("[TB] FAIL ovr_valid_kept: got %b expected 1", rx_valid); else pass_cnt++;
    endtask

    task automatic test_ready_at_done();
        // Completion is on tick 153 of the frame (mid start + 8 bits + 16 stop ticks).
        ready_tick = 153;
        send_frame(8'h3C, 1'b1);
        ready_tick = 0;
        check_cnt++; if (rx_valid !== 1'b1) $display("[TB] FAIL same_cycle_valid: got %b expected 1", rx_valid); else pass_cnt++;
        check_cnt++; if (data_out !== 8'h3C) $display("[TB] FAIL same_cycle_data: got %h expected 3c", data_out); else pass_cnt++;
        check_cnt++; if (overrun !== 1'b0) $display("[TB] FAIL same_cycle_ovr: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_framing_error();
        int d0;
        d0 = done_cnt;
        send_frame(8'hFF, 1'b0);
        check_cnt++; if (done_cnt - d0 !== 1) $display("[TB] FAIL fe_done_pulses: got %0d expected 1", done_cnt - d0); else pass_cnt++;
        check_cnt++; if (framing_error !== 1'b1) $display("[TB] FAIL fe_flag: got %b expected 1", framing_error); else pass_cnt++;
        check_cnt++; if (data_out !== 8'h3C) $display("[TB] FAIL fe_data_kept: got %h expected 3c", data_out); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b1) $display("[TB] FAIL fe_valid_kept: got %b expected 1", rx_valid); else pass_cnt++;
        @(negedge clk_100MHz); clr_err = 1'b1;
        @(negedge clk_100MHz); clr_err = 1'b0;
        check_cnt++; if (framing_error !== 1'b0) $display("[TB] FAIL fe_cleared: got %b expected 0", framing_error); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_cnt;
        saw_start = 1'b0;
        tick_idx = 0;
        rx = 1'b0;
        repeat (5) tick_once();
        rx = 1'b1;
        repeat (16) tick_once();
        check_cnt++; if (saw_start !== 1'b1) $display("[TB] FAIL glitch_start_seen: got %b expected 1", saw_start); else pass_cnt++;
        check_cnt++; if (state_out !== 2'b00) $display("[TB] FAIL glitch_idle: got %b expected 00", state_out); else pass_cnt++;
        check_cnt++; if (done_cnt - d0 !== 0) $display("[TB] FAIL glitch_no_done: got %0d expected 0", done_cnt - d0); else pass_cnt++;
        check_cnt++; if ({framing_error, overrun} !== 2'b00) $display("[TB] FAIL glitch_flags: got %b expected 00", {framing_error, overrun}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        tick_idx = 0;
        rx = 1'b0;
        repeat (40) tick_once();
        check_cnt++; if (state_out !== 2'b10) $display("[TB] FAIL mid_in_data: got %b expected 10", state_out); else pass_cnt++;
        @(negedge clk_100MHz); reset = 1'b1; rx = 1'b1;
        @(negedge clk_100MHz); reset = 1'b0;
        check_cnt++; if (state_out !== 2'b00) $display("[TB] FAIL mid_reset_state: got %b expected 00", state_out); else pass_cnt++;
        check_cnt++; if (data_out !== 8'h00) $display("[TB] FAIL mid_reset_data: got %h expected 00", data_out); else pass_cnt++;
        check_cnt++; if ({rx_valid, rx_done, framing_error, overrun} !== 4'b0000) $display("[TB] FAIL mid_reset_flags: got %b expected 0000", {rx_valid, rx_done, framing_error, overrun}); else pass_cnt++;
        repeat (4) @(negedge clk_100MHz);
        send_frame(8'h5A, 1'b1);
        check_cnt++; if (data_out !== 8'h5A) $display("[TB] FAIL after_reset_data: got %h expected 5a", data_out); else pass_cnt++;
        check_cnt++; if (rx_valid !== 1'b1) $display("[TB] FAIL after_reset_valid: got %b expected 1", rx_valid); else pass_cnt++;
        check_cnt++; if (overrun !== 1'b0) $display("[TB] FAIL after_reset_ovr: got %b expected 0", overrun); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_consume();
        test_overrun();
        test_ready_at_done();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 16x-oversampled UART receiver: the receive-side counterpart of uart_transmitter.
- Uses the same baud_rate_generator tick and the same DBITS/SB_TICK parameters.
- Recovers 8N1 frames (start bit, DBITS data bits LSB first, stop) from the rx line and presents each byte through a one-entry holding register with a valid/ready handshake.
- Reports framing and overrun errors, and exposes state_out for LED debug, matching the transmitter's debug port.

Parameters:
- DBITS, 8: number of data bits per frame.
- SB_TICK, 16: sample ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk_100MHz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- sample_tick  input  1  one-cycle pulse at 16x baud from baud_rate_generator.
- rx_ready  input  1  consumer accepts data_out this cycle.
- clr_err  input  1  one-cycle pulse; clears the sticky error flags.
- data_out  output  DBITS  last good received byte (holding register).
- rx_valid  output  1  data_out holds an unconsumed byte.
- rx_done  output  1  one-cycle pulse per completed frame, good or bad.
- framing_error  output  1  sticky; a frame ended with rx low at the stop sample.
- overrun  output  1  sticky; a good byte arrived while rx_valid=1 and was not consumed that cycle.
- state_out  output  2  current FSM state, for debug.

Behaviour:
- Interface (already decided): single clock clk_100MHz; reset is synchronous and active-high.
- Reset values:
  - Synchronizer flops = 1; state = IDLE (state_out = 2'b00).
  - s_cnt = 0, n = 0, shift register = 0.
  - data_out = 0; rx_valid, rx_done, framing_error, overrun = 0.
- Synchronizer: rx passes through 2 flops to give rx_s. All sampling uses rx_s (2-cycle input latency).
- Counters:
  - s_cnt is 5 bits, wide enough for SB_TICK up to 32.
  - n is ceil(log2(DBITS)) bits.
  - Counters advance only on cycles where sample_tick=1.
- FSM (state_out encoding: IDLE=00, START=01, DATA=10, STOP=11):
  - IDLE: when rx_s=0 (no tick needed), go to START with s_cnt=0. Ticks are ignored while in IDLE.
  - START: on a tick with s_cnt=7 (mid start bit):
    - rx_s=0: go to DATA, s_cnt=0, n=0.
    - rx_s=1: glitch; go back to IDLE with no flags and no rx_done.
    - Otherwise s_cnt++.
  - DATA: on a tick with s_cnt=15:
    - shift = {rx_s, shift[DBITS-1:1]}, s_cnt=0.
    - If n=DBITS-1, go to STOP; else n++.
    - Otherwise s_cnt++.
  - STOP: on a tick with s_cnt=SB_TICK-1, go to IDLE and complete the frame (sample rx_s); otherwise s_cnt++.
- Frame completion, on the completing edge (outputs visible the next cycle):
  - rx_done = 1 for exactly one cycle.
  - rx_s=1 (good frame): data_out <= shift and rx_valid <= 1. If rx_valid was already 1 and rx_ready=0 that cycle, set overrun; the new byte overwrites the old one.
  - rx_s=0 (bad frame): set framing_error. The byte is discarded; data_out and rx_valid are unchanged.
- Handshake:
  - rx_valid && rx_ready clears rx_valid on the next edge. data_out holds its value until the next good frame.
  - A good completion and rx_ready in the same cycle: rx_valid stays 1, data_out takes the new byte, no overrun.
- Error flags:
  - clr_err clears framing_error and overrun.
  - clr_err coinciding with a new error: the set wins.
- Back-to-back frames: after STOP, a falling edge of rx_s is detected in IDLE on the very next cycle, so there is no dead time.
- Reset mid-frame: returns immediately to the reset values and the partial frame is lost. If the line is held low after reset, the FSM enters START, then validates at the next s_cnt=7.
- rx stuck low (break): each frame ends with framing_error and rx_done, then the receiver re-enters START immediately and repeats.

Test Plan:
- Send 8'd65 with 1 stop bit: line sequence 0,1,0,0,0,0,0,1,0,1, each bit 16 ticks, tick every 4 clocks. Required: rx_done one pulse; data_out=8'h41; rx_valid=1; framing_error=0; state_out returns to 00.
- Send 8'h41 with rx_ready held low, then 8'hA5. Required: data_out=8'hA5, rx_valid=1, overrun=1. Then pulse clr_err; required: overrun=0 and rx_valid still 1.
- Send 8'h3C with rx_ready pulsed on the exact cycle the second frame completes. Required: rx_valid=1, data_out=8'h3C, overrun=0.
- Drive the stop bit low on a frame of 8'hFF. Required: rx_done pulses, framing_error=1, rx_valid and data_out unchanged from the prior byte.
- Drive rx low for 5 ticks then high. Required: FSM goes IDLE→START→IDLE, no rx_done, no flags.
- Assert reset for 1 cycle during the DATA state of a frame. Required: all outputs zero and state_out=00 the next cycle. Then a following full frame of 8'h5A is received correctly.
